dsk_track_nibblizer: RTL and testbench

- Converts one 16-sector track of a DSK/DO/PO sector image into a 6656-byte GCR nibble track.
- Output format is identical to a NIB track, so the floppy controller's track RAM can serve sector images unchanged.
- Sits between the floppy track loader's 4 KB sector buffer (filled from sd_buff) and the disk track RAM behind the Apple II disk controller.
- Runs in the clk_sys domain, once per track load.

---
 rtl/dsk_nib_pkg.sv | 65 ++++++
 rtl/nib62_encoder.sv | 23 ++
 rtl/dsk_track_nibblizer.sv | 184 ++++++++++++++++++
 tb/tb_dsk_track_nibblizer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsk_nib_pkg.sv
// Shared constants for the sector-image to GCR nibble track converter:
// FSM state codes, track geometry, 6&2 translate table, sector interleaves, 4&4 helpers.
package dsk_nib_pkg;

  localparam int TRACK_LEN = 6656;
  localparam int GAP1_LEN  = 48;
  localparam int GAP2_LEN  = 6;
  localparam int GAP3_LEN  = 27;

  typedef logic [3:0] state_t;
  localparam state_t S_IDLE  = 4'd0;
  localparam state_t S_GAP1  = 4'd1;
  localparam state_t S_ADDR  = 4'd2;
  localparam state_t S_GAP2  = 4'd3;
  localparam state_t S_DPRO  = 4'd4;
  localparam state_t S_DAUX  = 4'd5;
  localparam state_t S_DPRIM = 4'd6;
  localparam state_t S_DCSUM = 4'd7;
  localparam state_t S_DEPI  = 4'd8;
  localparam state_t S_GAP3  = 4'd9;
  localparam state_t S_PAD   = 4'd10;
  localparam state_t S_DONE  = 4'd11;

  localparam logic [7:0] PRO_D5     = 8'hD5;
  localparam logic [7:0] MARK_AA    = 8'hAA;
  localparam logic [7:0] ADDR_PRO_3 = 8'h96;
  localparam logic [7:0] DATA_PRO_3 = 8'hAD;
  localparam logic [7:0] EPI_DE     = 8'hDE;
  localparam logic [7:0] EPI_EB     = 8'hEB;
  localparam logic [7:0] SYNC_FF    = 8'hFF;

  localparam logic [7:0] GCR62 [64] = '{
    8'h96, 8'h97, 8'h9A, 8'h9B, 8'h9D, 8'h9E, 8'h9F, 8'hA6,
    8'hA7, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB2, 8'hB3,
    8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB9, 8'hBA, 8'hBB, 8'hBC,
    8'hBD, 8'hBE, 8'hBF, 8'hCB, 8'hCD, 8'hCE, 8'hCF, 8'hD3,
    8'hD6, 8'hD7, 8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE,
    8'hDF, 8'hE5, 8'hE6, 8'hE7, 8'hE9, 8'hEA, 8'hEB, 8'hEC,
    8'hED, 8'hEE, 8'hEF, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6,
    8'hF7, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF
  };

  localparam logic [3:0] ILV_DOS [16] = '{
    4'd0, 4'd7, 4'd14, 4'd6, 4'd13, 4'd5, 4'd12, 4'd4,
    4'd11, 4'd3, 4'd10, 4'd2, 4'd9, 4'd1, 4'd8, 4'd15
  };

  localparam logic [3:0] ILV_PRODOS [16] = '{
    4'd0, 4'd8, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11,
    4'd4, 4'd12, 4'd5, 4'd13, 4'd6, 4'd14, 4'd7, 4'd15
  };

  function automatic logic [7:0] enc44_odd(input logic [7:0] b);
    return (b >> 1) | 8'hAA;
  endfunction

  function automatic logic [7:0] enc44_even(input logic [7:0] b);
    return b | 8'hAA;
  endfunction

  function automatic logic [1:0] rev2(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

endpackage

// File: rtl/nib62_encoder.sv
// 6&2 data-field encoder: XOR-chains each 6-bit value against the previous one and translates to GCR.
// Combinational nibble out, chain register updates on val_vld; csum emits the chain tail.
module nib62_encoder (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       clr,
  input  logic [5:0] val,
  input  logic       val_vld,
  input  logic       csum,
  output logic [7:0] nib
);
  import dsk_nib_pkg::*;

  logic [5:0] prev;

  always_ff @(posedge clk_sys) begin
    if (reset || clr) prev <= 6'd0;
    else if (val_vld) prev <= val;
  end

  assign nib = csum ? GCR62[prev] : GCR62[val ^ prev];

endmodule

// File: rtl/dsk_track_nibblizer.sv
// Converts one 16-sector DSK/DO/PO track into a 6656-nibble NIB-format GCR track.
// About 10.8k cycles per track; no backpressure, the track RAM must take a write on any cycle.
module dsk_track_nibblizer (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  volume,
  input  logic [5:0]  track,
  input  logic        po_order,
  output logic        busy,
  output logic        done,
  output logic [11:0] src_addr,
  input  logic [7:0]  src_data,
  output logic [12:0] nib_addr,
  output logic [7:0]  nib_data,
  output logic        nib_we
);
  import dsk_nib_pkg::*;

  state_t      state, next_state;
  logic [8:0]  cnt;
  logic [3:0]  sect;
  logic [1:0]  phase;
  logic [12:0] wr_cnt;
  logic [7:0]  vol_q;
  logic [5:0]  trk_q;
  logic        po_q;
  logic [1:0]  a0, a1, hi;
  logic [3:0]  lsec;
  logic [7:0]  src_byte, addr_nib, wr_dat, csum44;
  logic [5:0]  enc_val;
  logic [7:0]  enc_nib;
  logic        wr_en, seg_done, adv;

  assign lsec   = po_q ? ILV_PRODOS[sect] : ILV_DOS[sect];
  assign csum44 = vol_q ^ {2'b00, trk_q} ^ {4'd0, sect};

  // Aux value i gathers b[i], b[i+86], b[i+172]; the last one lies past the sector for i >= 84.
  always_comb begin
    src_byte = cnt[7:0];
    if (state == S_DAUX) begin
      case (phase)
        2'd1:    src_byte = cnt[7:0] + 8'd86;
        2'd2:    src_byte = cnt[7:0] + 8'd172;
        default: src_byte = cnt[7:0];
      endcase
    end
  end

  assign src_addr = (state == S_DAUX || state == S_DPRIM) ? {lsec, src_byte} : 12'd0;
  assign hi       = (cnt >= 9'd84) ? 2'b00 : rev2(src_data[1:0]);
  assign enc_val  = (state == S_DAUX) ? {hi, a1, a0} : src_data[7:2];
  assign adv      = (state != S_DAUX) || (phase == 2'd3);

  nib62_encoder u_enc (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (state == S_DPRO),
    .val     (enc_val),
    .val_vld ((state == S_DAUX && phase == 2'd3) || (state == S_DPRIM && cnt != 9'd0)),
    .csum    (state == S_DCSUM),
    .nib     (enc_nib)
  );

  always_comb begin
    case (cnt[3:0])
      4'd0:    addr_nib = PRO_D5;
      4'd1:    addr_nib = MARK_AA;
      4'd2:    addr_nib = ADDR_PRO_3;
      4'd3:    addr_nib = enc44_odd(vol_q);
      4'd4:    addr_nib = enc44_even(vol_q);
      4'd5:    addr_nib = enc44_odd({2'b00, trk_q});
      4'd6:    addr_nib = enc44_even({2'b00, trk_q});
      4'd7:    addr_nib = enc44_odd({4'd0, sect});
      4'd8:    addr_nib = enc44_even({4'd0, sect});
      4'd9:    addr_nib = enc44_odd(csum44);
      4'd10:   addr_nib = enc44_even(csum44);
      4'd11:   addr_nib = EPI_DE;
      4'd12:   addr_nib = MARK_AA;
      default: addr_nib = EPI_EB;
    endcase
  end

  always_comb begin
    wr_en      = 1'b0;
    wr_dat     = SYNC_FF;
    seg_done   = 1'b0;
    next_state = state;
    case (state)
      S_GAP1:  begin wr_en = 1'b1; seg_done = (cnt == 9'(GAP1_LEN - 1)); next_state = S_ADDR; end
      S_ADDR:  begin wr_en = 1'b1; wr_dat = addr_nib; seg_done = (cnt == 9'd13); next_state = S_GAP2; end
      S_GAP2:  begin wr_en = 1'b1; seg_done = (cnt == 9'(GAP2_LEN - 1)); next_state = S_DPRO; end
      S_DPRO: begin
        wr_en      = 1'b1;
        wr_dat     = (cnt[1:0] == 2'd0) ? PRO_D5 : (cnt[1:0] == 2'd1) ? MARK_AA : DATA_PRO_3;
        seg_done   = (cnt == 9'd2);
        next_state = S_DAUX;
      end
      S_DAUX:  begin wr_en = (phase == 2'd3); wr_dat = enc_nib; seg_done = (cnt == 9'd85); next_state = S_DPRIM; end
      // One-cycle read latency: the write for byte j lands while byte j+1 is addressed.
      S_DPRIM: begin wr_en = (cnt != 9'd0); wr_dat = enc_nib; seg_done = (cnt == 9'd256); next_state = S_DCSUM; end
      S_DCSUM: begin wr_en = 1'b1; wr_dat = enc_nib; seg_done = 1'b1; next_state = S_DEPI; end
      S_DEPI: begin
        wr_en      = 1'b1;
        wr_dat     = (cnt[1:0] == 2'd0) ? EPI_DE : (cnt[1:0] == 2'd1) ? MARK_AA : EPI_EB;
        seg_done   = (cnt == 9'd2);
        next_state = S_GAP3;
      end
      S_GAP3: begin
        wr_en      = 1'b1;
        seg_done   = (cnt == 9'(GAP3_LEN - 1));
        next_state = (sect == 4'd15) ? S_PAD : S_ADDR;
      end
      S_PAD:   begin wr_en = 1'b1; seg_done = (wr_cnt == 13'(TRACK_LEN - 1)); next_state = S_DONE; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 9'd0;
      sect     <= 4'd0;
      phase    <= 2'd0;
      wr_cnt   <= 13'd0;
      vol_q    <= 8'd0;
      trk_q    <= 6'd0;
      po_q     <= 1'b0;
      a0       <= 2'd0;
      a1       <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nib_we   <= 1'b0;
      nib_addr <= 13'd0;
      nib_data <= 8'd0;
    end else begin
      nib_we <= 1'b0;
      done   <= 1'b0;
      if (wr_en) begin
        nib_we   <= 1'b1;
        nib_data <= wr_dat;
        nib_addr <= wr_cnt;
        wr_cnt   <= wr_cnt + 13'd1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            vol_q  <= volume;
            trk_q  <= track;
            po_q   <= po_order;
            busy   <= 1'b1;
            cnt    <= 9'd0;
            sect   <= 4'd0;
            phase  <= 2'd0;
            wr_cnt <= 13'd0;
            state  <= S_GAP1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          if (state == S_DAUX) begin
            phase <= phase + 2'd1;
            if (phase == 2'd1) a0 <= rev2(src_data[1:0]);
            if (phase == 2'd2) a1 <= rev2(src_data[1:0]);
          end
          if (adv) begin
            if (seg_done) begin
              cnt   <= 9'd0;
              state <= next_state;
              if (state == S_GAP3) sect <= sect + 4'd1;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsk_track_nibblizer.sv
// Directed bench for dsk_track_nibblizer: fixed patterns with hand-derived nibbles,
// a 6&2 decoder for sector content, and an independent track model for byte-exact compares.
module tb_dsk_track_nibblizer;

  logic        clk_sys = 1'b0;
  logic        reset, start, po_order;
  logic [7:0]  volume;
  logic [5:0]  track;
  logic        busy, done, nib_we;
  logic [11:0] src_addr;
  logic [7:0]  src_data;
  logic [12:0] nib_addr;
  logic [7:0]  nib_data;

  always #35 clk_sys = ~clk_sys;

  dsk_track_nibblizer dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (start),
    .volume   (volume),
    .track    (track),
    .po_order (po_order),
    .busy     (busy),
    .done     (done),
    .src_addr (src_addr),
    .src_data (src_data),
    .nib_addr (nib_addr),
    .nib_data (nib_data),
    .nib_we   (nib_we)
  );

  localparam logic [7:0] T_GCR [64] = '{
    8'h96, 8'h97, 8'h9A, 8'h9B, 8'h9D, 8'h9E, 8'h9F, 8'hA6,
    8'hA7, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB2, 8'hB3,
    8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB9, 8'hBA, 8'hBB, 8'hBC,
    8'hBD, 8'hBE, 8'hBF, 8'hCB, 8'hCD, 8'hCE, 8'hCF, 8'hD3,
    8'hD6, 8'hD7, 8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE,
    8'hDF, 8'hE5, 8'hE6, 8'hE7, 8'hE9, 8'hEA, 8'hEB, 8'hEC,
    8'hED, 8'hEE, 8'hEF, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6,
    8'hF7, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF
  };
  localparam int T_DOS [16] = '{0, 7, 14, 6, 13, 5, 12, 4, 11, 3, 10, 2, 9, 1, 8, 15};
  localparam int T_PRO [16] = '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15};
  localparam logic [7:0] HDR_ZERO [14] = '{
    8'hD5, 8'hAA, 8'h96, 8'hFF, 8'hFE, 8'hAA, 8'hAA,
    8'hAA, 8'hAA, 8'hFF, 8'hFE, 8'hDE, 8'hAA, 8'hEB
  };

  logic [7:0] src_mem [4096];
  logic [7:0] got     [6656];
  logic [7:0] exp_trk [6656];
  int         exp_n;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         mw, md, mbad;
  logic       mon_clr;
  int         scratch;
  logic [7:0] vol_r;
  logic [5:0] trk_r;
  bit         hit;

  always @(posedge clk_sys) src_data <= src_mem[src_addr];

  always @(negedge clk_sys) begin
    if (mon_clr) begin
      mw <= 0; md <= 0; mbad <= 0;
    end else begin
      if (nib_we === 1'b1) begin
        if (mw < 6656 && nib_addr == 13'(mw)) got[mw] <= nib_data;
        else mbad <= mbad + 1;
        mw <= mw + 1;
      end
      if (done === 1'b1) md <= md + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic mon_clear();
    @(posedge clk_sys); #1 mon_clr = 1'b1;
    @(negedge clk_sys); #1 mon_clr = 1'b0;
  endtask

  task automatic put(input logic [7:0] x);
    exp_trk[exp_n] = x;
    exp_n++;
  endtask

  function automatic logic [1:0] swap2(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  task automatic build_exp(input logic [7:0] vol, input logic [5:0] trk, input logic po);
    logic [7:0] b [256];
    logic [5:0] v [342];
    logic [5:0] pv;
    logic [7:0] f [4];
    logic [7:0] b172;
    int         ls;
    exp_n = 0;
    for (int i = 0; i < 48; i++) put(8'hFF);
    for (int p = 0; p < 16; p++) begin
      ls = po ? T_PRO[p] : T_DOS[p];
      f[0] = vol; f[1] = {2'b00, trk}; f[2] = 8'(p); f[3] = vol ^ {2'b00, trk} ^ 8'(p);
      put(8'hD5); put(8'hAA); put(8'h96);
      for (int k = 0; k < 4; k++) begin put((f[k] >> 1) | 8'hAA); put(f[k] | 8'hAA); end
      put(8'hDE); put(8'hAA); put(8'hEB);
      for (int i = 0; i < 6; i++) put(8'hFF);
      put(8'hD5); put(8'hAA); put(8'hAD);
      for (int i = 0; i < 256; i++) b[i] = src_mem[ls * 256 + i];
      for (int i = 0; i < 86; i++) begin
        b172 = (i + 172 < 256) ? b[i + 172] : 8'h00;
        v[i] = {swap2(b172[1:0]), swap2(b[i + 86][1:0]), swap2(b[i][1:0])};
      end
      for (int j = 0; j < 256; j++) v[86 + j] = b[j][7:2];
      pv = 6'd0;
      for (int k = 0; k < 342; k++) begin put(T_GCR[v[k] ^ pv]); pv = v[k]; end
      put(T_GCR[pv]);
      put(8'hDE); put(8'hAA); put(8'hEB);
      for (int i = 0; i < 27; i++) put(8'hFF);
    end
    while (exp_n < 6656) put(8'hFF);
  endtask

  task automatic compare_model(input logic [7:0] vol, input logic [5:0] trk, input logic po, input string nm);
    int nbad, first;
    build_exp(vol, trk, po);
    nbad = 0; first = -1;
    for (int i = 0; i < 6656; i++)
      if (got[i] !== exp_trk[i]) begin
        if (first < 0) first = i;
        nbad++;
      end
    check($sformatf("%s_model_mismatches(first@%0d)", nm, first), nbad, 0);
  endtask

  task automatic decode_phys(input int p, input logic [7:0] want, input string nm);
    logic [5:0] v [342];
    logic [5:0] pv;
    logic [1:0] lo;
    logic [7:0] byt;
    int         base, nbad, nogcr, idx;
    base = 71 + 396 * p;
    pv = 6'd0; nogcr = 0; nbad = 0;
    for (int k = 0; k <= 342; k++) begin
      idx = -1;
      for (int t = 0; t < 64; t++) if (T_GCR[t] == got[base + k]) idx = t;
      if (idx < 0) begin nogcr++; idx = 0; end
      if (k < 342) begin v[k] = 6'(idx) ^ pv; pv = v[k]; end
      else check({nm, "_csum"}, 6'(idx), pv);
    end
    check({nm, "_invalid_gcr"}, nogcr, 0);
    for (int j = 0; j < 256; j++) begin
      if (j < 86) lo = v[j][1:0];
      else if (j < 172) lo = v[j - 86][3:2];
      else lo = v[j - 172][5:4];
      byt = {v[86 + j], lo[0], lo[1]};
      if (j == 0) check({nm, "_byte0"}, byt, want);
      if (byt !== want) nbad++;
    end
    check({nm, "_bad_bytes"}, nbad, 0);
  endtask

  task automatic run_track(input logic [7:0] vol, input logic [5:0] trk, input logic po,
                           input bit dbl, input string nm);
    bit seen;
    mon_clear();
    @(posedge clk_sys); #1;
    volume = vol; track = trk; po_order = po; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    check({nm, "_busy_rise"}, busy, 1);
    volume = ~vol; track = ~trk; po_order = ~po;
    seen = 1'b0;
    for (int c = 1; c <= 16384; c++) begin
      start = (dbl && c == 200);
      @(posedge clk_sys); #1;
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    check({nm, "_done_in_bound"}, seen, 1);
    check({nm, "_busy_fall"}, busy, 0);
    repeat (3) @(negedge clk_sys);
    @(posedge clk_sys); #1;
    check({nm, "_write_count"}, mw, 6656);
    check({nm, "_done_pulses"}, md, 1);
    check({nm, "_order_errors"}, mbad, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; volume = 8'd0; track = 6'd0; po_order = 1'b0; mon_clr = 1'b1;
    for (int i = 0; i < 4096; i++) src_mem[i] = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nib_we", nib_we, 0);
    check("rst_nib_addr", nib_addr, 0);
    check("rst_nib_data", nib_data, 0);
    check("rst_src_addr", src_addr, 0);
    reset = 1'b0; mon_clr = 1'b0;

    // All-zero image, with a second start pulse while busy
    run_track(8'hFE, 6'd0, 1'b0, 1'b1, "zero");
    for (int i = 0; i < 48; i++) check($sformatf("zero_gap1[%0d]", i), got[i], 8'hFF);
    for (int i = 0; i < 14; i++) check($sformatf("zero_addr[%0d]", 48 + i), got[48 + i], HDR_ZERO[i]);
    for (int i = 62; i < 68; i++) check($sformatf("zero_gap2[%0d]", i), got[i], 8'hFF);
    check("zero_dpro0", got[68], 8'hD5);
    check("zero_dpro1", got[69], 8'hAA);
    check("zero_dpro2", got[70], 8'hAD);
    scratch = 0;
    for (int i = 71; i < 414; i++) if (got[i] !== 8'h96) scratch++;
    check("zero_data_not96", scratch, 0);
    check("zero_epi0", got[414], 8'hDE);
    check("zero_epi1", got[415], 8'hAA);
    check("zero_epi2", got[416], 8'hEB);
    scratch = 0;
    for (int i = 6384; i < 6656; i++) if (got[i] !== 8'hFF) scratch++;
    check("zero_pad_notFF", scratch, 0);
    compare_model(8'hFE, 6'd0, 1'b0, "zero");

    // Logical sector L filled with L, sector 0 byte 0 = 0x03
    for (int l = 0; l < 16; l++) for (int i = 0; i < 256; i++) src_mem[l * 256 + i] = 8'(l);
    src_mem[0] = 8'h03;
    run_track(8'hFE, 6'd17, 1'b0, 1'b0, "fill_dos");
    check("p0_data0", got[71], 8'h9B);
    check("p0_data1", got[72], 8'h9B);
    check("p0_data2", got[73], 8'h96);
    check("p0_data3", got[74], 8'h96);
    check("p0_csum", got[413], 8'h96);
    check("s15_trk_odd", got[5988 + 5], 8'hAA);
    check("s15_trk_even", got[5988 + 6], 8'hBB);
    check("s15_sec_odd", got[5988 + 7], 8'hAF);
    check("s15_sec_even", got[5988 + 8], 8'hAF);
    check("s15_cs_odd", got[5988 + 9], 8'hFA);
    check("s15_cs_even", got[5988 + 10], 8'hEA);
    decode_phys(1, 8'h07, "dos_p1");
    decode_phys(15, 8'h0F, "dos_p15");
    compare_model(8'hFE, 6'd17, 1'b0, "fill_dos");

    run_track(8'h01, 6'd5, 1'b1, 1'b0, "fill_po");
    decode_phys(1, 8'h08, "po_p1");
    compare_model(8'h01, 6'd5, 1'b1, "fill_po");

    // Abort at write 3000, then a clean random track
    for (int i = 0; i < 4096; i++) src_mem[i] = 8'($urandom);
    vol_r = 8'($urandom);
    trk_r = 6'($urandom_range(0, 34));
    mon_clear();
    @(posedge clk_sys); #1;
    volume = vol_r; track = trk_r; po_order = 1'b0; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 16384; c++) begin
      @(posedge clk_sys); #1;
      if (nib_we === 1'b1 && nib_addr == 13'd3000) begin hit = 1'b1; break; end
    end
    check("abort_reached_3000", hit, 1);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    check("abort_nib_we", nib_we, 0);
    check("abort_busy", busy, 0);
    reset = 1'b0;
    scratch = 0;
    repeat (40) begin
      @(posedge clk_sys); #1;
      if (nib_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) scratch++;
    end
    check("abort_quiet_cycles", scratch, 0);
    check("abort_write_count", mw, 3001);
    check("abort_done_pulses", md, 0);
    run_track(vol_r, trk_r, 1'b0, 1'b0, "rand_dos");
    compare_model(vol_r, trk_r, 1'b0, "rand_dos");

    for (int i = 0; i < 4096; i++) src_mem[i] = 8'($urandom);
    vol_r = 8'($urandom);
    trk_r = 6'($urandom_range(0, 34));
    run_track(vol_r, trk_r, 1'b1, 1'b0, "rand_po");
    compare_model(vol_r, trk_r, 1'b1, "rand_po");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
